// File: rtl/xadc_chan_monitor_if.sv
// ---------------------------------------------------------------------------
// xadc_chan_monitor_if
// DRP/XADC-side bundle of the channel monitor.
//
// Handshake: a read is a request/complete pair with no back-pressure. The
// master raises den for exactly one clk_ctrl cycle with daddr valid in the
// same cycle. The slave later raises xadc_drdy for one cycle with xadc_do
// valid in that cycle. The master never issues a second den until the first
// read has completed or been abandoned. xadc_eoc is a single-cycle event
// with xadc_channel valid alongside it; it has no ready and cannot be
// stalled.
//
// Signals
//   xadc_eoc      slave->master  end-of-conversion pulse
//   xadc_channel  slave->master  channel just converted (5 bits)
//   xadc_drdy     slave->master  DRP read data valid
//   xadc_do       slave->master  DRP read data, code in [15:4]
//   daddr         master->slave  DRP address (7 bits)
//   den           master->slave  DRP enable, single cycle
// ---------------------------------------------------------------------------
interface xadc_chan_monitor_if;
  logic        xadc_eoc;
  logic [4:0]  xadc_channel;
  logic        xadc_drdy;
  logic [15:0] xadc_do;
  logic [6:0]  daddr;
  logic        den;

  modport master (
    output daddr,
    output den,
    input  xadc_eoc,
    input  xadc_channel,
    input  xadc_drdy,
    input  xadc_do
  );

  modport slave (
    input  daddr,
    input  den,
    output xadc_eoc,
    output xadc_channel,
    output xadc_drdy,
    output xadc_do
  );
endinterface

// File: rtl/xadc_chan_monitor.sv
// ---------------------------------------------------------------------------
// xadc_chan_monitor
// Watches XADC end-of-conversion events, reads the converted code of each
// monitored channel over the DRP, keeps a per-channel boxcar average of
// 2^AVG_LOG2 conversions and drives per-channel over/under-voltage alarms
// with release hysteresis.
//
// Ports
//   clk_ctrl      in   sole clock (DRP clock)
//   rst_ctrl      in   asynchronous active-high reset
//   drp           --   xadc_chan_monitor_if.master (eoc/channel/drdy/do in,
//                      daddr/den out)
//   ov_thr        in   NUM_CH x 12 over-voltage thresholds (static)
//   uv_thr        in   NUM_CH x 12 under-voltage thresholds (static)
//   sample        out  NUM_CH x 12 latest averaged code per channel
//   sample_valid  out  one-cycle strobe: one channel's sample updated
//   sample_ch     out  index of the updated channel
//   ov_alarm      out  per-channel over-voltage alarm level
//   uv_alarm      out  per-channel under-voltage alarm level
//   drdy_timeout  out  sticky: a DRP read never completed
//   eoc_overrun   out  sticky: EOC arrived while a read was in flight
//   dbg_state     out  FSM state (0 IDLE, 1 WAIT, 2 ACC)
// ---------------------------------------------------------------------------
module xadc_chan_monitor #(
  parameter int                  NUM_CH       = 4,
  parameter logic [NUM_CH*7-1:0] CH_ADDR      = {7'h13, 7'h12, 7'h11, 7'h15},
  parameter int                  AVG_LOG2     = 2,
  parameter logic [11:0]         HYST         = 12'd16,
  parameter int                  DRDY_TIMEOUT = 64
) (
  input  logic                   clk_ctrl,
  input  logic                   rst_ctrl,
  xadc_chan_monitor_if.master    drp,
  input  logic [NUM_CH*12-1:0]   ov_thr,
  input  logic [NUM_CH*12-1:0]   uv_thr,
  output logic [NUM_CH*12-1:0]   sample,
  output logic                   sample_valid,
  output logic [2:0]             sample_ch,
  output logic [NUM_CH-1:0]      ov_alarm,
  output logic [NUM_CH-1:0]      uv_alarm,
  output logic                   drdy_timeout,
  output logic                   eoc_overrun,
  output logic [1:0]             dbg_state
);

  // Accumulator holds up to 2^AVG_LOG2 codes of 12 bits: never overflows.
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TW = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [11:0]           code_q, code_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  den_q, den_d;
  logic [6:0]            daddr_q, daddr_d;
  logic [AW-1:0]         acc_q [NUM_CH];
  logic [AW-1:0]         acc_d [NUM_CH];
  logic [CW-1:0]         cnt_q [NUM_CH];
  logic [CW-1:0]         cnt_d [NUM_CH];
  logic [NUM_CH*12-1:0]  sample_q, sample_d;
  logic                  sv_q, sv_d;
  logic [2:0]            sch_q, sch_d;
  logic [NUM_CH-1:0]     ov_q, ov_d;
  logic [NUM_CH-1:0]     uv_q, uv_d;
  logic                  tmo_flag_q, tmo_flag_d;
  logic                  ovr_q, ovr_d;

  // Channel match and per-channel selection
  logic                  hit;
  logic [2:0]            hit_idx;
  logic [6:0]            hit_addr;
  logic [AW-1:0]         acc_sel;
  logic [CW-1:0]         cnt_sel;
  logic [11:0]           ov_sel, uv_sel;
  logic                  ov_cur, uv_cur;
  logic [AW-1:0]         sum_w;
  logic [11:0]           avg_w;
  logic [11:0]           ov_lo;
  logic [12:0]           uv_sum;
  logic [11:0]           uv_hi;
  logic                  ov_next, uv_next;

  // The low nibble of the DRP word carries no code bits.
  logic                  unused_do_bits;
  assign unused_do_bits = &drp.xadc_do[3:0];

  // Match the converted channel against the address table. Scanning from
  // the top index down lets the lowest matching index win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 3'd0;
    hit_addr = 7'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ({2'b00, drp.xadc_channel} == CH_ADDR[i*7 +: 7]) begin
        hit      = 1'b1;
        hit_idx  = 3'(i);
        hit_addr = CH_ADDR[i*7 +: 7];
      end
    end
  end

  // Pick the state and thresholds of the channel whose read is in flight.
  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    ov_sel  = 12'd0;
    uv_sel  = 12'd0;
    ov_cur  = 1'b0;
    uv_cur  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == 3'(i)) begin
        acc_sel = acc_q[i];
        cnt_sel = cnt_q[i];
        ov_sel  = ov_thr[i*12 +: 12];
        uv_sel  = uv_thr[i*12 +: 12];
        ov_cur  = ov_q[i];
        uv_cur  = uv_q[i];
      end
    end
  end

  // Average of the completed window plus alarm decisions on that average.
  // Release thresholds saturate at 0 / 4095; equality with either the set
  // or release threshold keeps the current alarm level.
  always_comb begin
    sum_w  = acc_sel + AW'(code_q);
    avg_w  = sum_w[AVG_LOG2 +: 12];
    ov_lo  = (ov_sel >= HYST) ? (ov_sel - HYST) : 12'd0;
    uv_sum = {1'b0, uv_sel} + {1'b0, HYST};
    uv_hi  = uv_sum[12] ? 12'hFFF : uv_sum[11:0];

    if (avg_w > ov_sel)      ov_next = 1'b1;
    else if (avg_w < ov_lo)  ov_next = 1'b0;
    else                     ov_next = ov_cur;

    if (avg_w < uv_sel)      uv_next = 1'b1;
    else if (avg_w > uv_hi)  uv_next = 1'b0;
    else                     uv_next = uv_cur;
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    tmo_d      = tmo_q;
    den_d      = 1'b0;
    daddr_d    = daddr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    sv_d       = 1'b0;
    sch_d      = sch_q;
    ov_d       = ov_q;
    uv_d       = uv_q;
    tmo_flag_d = tmo_flag_q;
    ovr_d      = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (drp.xadc_eoc && hit) begin
          den_d   = 1'b1;
          daddr_d = hit_addr;
          idx_d   = hit_idx;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A conversion finishing now cannot be read: it is dropped.
        if (drp.xadc_eoc) ovr_d = 1'b1;
        if (drp.xadc_drdy) begin
          code_d  = drp.xadc_do[15:4];
          state_d = S_ACC;
        end else if (tmo_q == TW'(DRDY_TIMEOUT - 1)) begin
          tmo_flag_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_ACC: begin
        if (drp.xadc_eoc) ovr_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx_q == 3'(i)) begin
            if (cnt_sel == CNT_LAST) begin
              sample_d[i*12 +: 12] = avg_w;
              acc_d[i]             = '0;
              cnt_d[i]             = '0;
              sv_d                 = 1'b1;
              sch_d                = 3'(i);
              ov_d[i]              = ov_next;
              uv_d[i]              = uv_next;
            end else begin
              acc_d[i] = sum_w;
              cnt_d[i] = cnt_sel + CW'(1);
            end
          end
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      code_q     <= 12'd0;
      tmo_q      <= '0;
      den_q      <= 1'b0;
      daddr_q    <= 7'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      sample_q   <= '0;
      sv_q       <= 1'b0;
      sch_q      <= 3'd0;
      ov_q       <= '0;
      uv_q       <= '0;
      tmo_flag_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      tmo_q      <= tmo_d;
      den_q      <= den_d;
      daddr_q    <= daddr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      sv_q       <= sv_d;
      sch_q      <= sch_d;
      ov_q       <= ov_d;
      uv_q       <= uv_d;
      tmo_flag_q <= tmo_flag_d;
      ovr_q      <= ovr_d;
    end
  end

  assign drp.den      = den_q;
  assign drp.daddr    = daddr_q;
  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign ov_alarm     = ov_q;
  assign uv_alarm     = uv_q;
  assign drdy_timeout = tmo_flag_q;
  assign eoc_overrun  = ovr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_xadc_chan_monitor.sv
// ---------------------------------------------------------------------------
// tb_xadc_chan_monitor
// Three monitors share one XADC stimulus stream, each answering to its own
// channel addresses:
//   dut_a  4 channels (0x15,0x11,0x12,0x13), 4-sample average, random run
//   dut_b  2 channels both at 0x16, no averaging, hysteresis sequence
//   dut_c  1 channel at 0x17, 4-sample average, 100/200/300/400 sequence
// ---------------------------------------------------------------------------
module tb_xadc_chan_monitor;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam int         HYST    = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared XADC stimulus
  logic        eoc, drdy;
  logic [4:0]  chan;
  logic [15:0] dout;

  xadc_chan_monitor_if if_a ();
  xadc_chan_monitor_if if_b ();
  xadc_chan_monitor_if if_c ();

  assign if_a.xadc_eoc = eoc;  assign if_a.xadc_channel = chan;
  assign if_a.xadc_drdy = drdy; assign if_a.xadc_do = dout;
  assign if_b.xadc_eoc = eoc;  assign if_b.xadc_channel = chan;
  assign if_b.xadc_drdy = drdy; assign if_b.xadc_do = dout;
  assign if_c.xadc_eoc = eoc;  assign if_c.xadc_channel = chan;
  assign if_c.xadc_drdy = drdy; assign if_c.xadc_do = dout;

  // dut_a
  logic [47:0] ov_thr_a, uv_thr_a, sample_a;
  logic        sv_a, tmo_a, ovr_a;
  logic [2:0]  sch_a;
  logic [3:0]  ov_a, uv_a;
  logic [1:0]  st_a;

  xadc_chan_monitor dut_a (
    .clk_ctrl(clk), .rst_ctrl(rst), .drp(if_a),
    .ov_thr(ov_thr_a), .uv_thr(uv_thr_a),
    .sample(sample_a), .sample_valid(sv_a), .sample_ch(sch_a),
    .ov_alarm(ov_a), .uv_alarm(uv_a),
    .drdy_timeout(tmo_a), .eoc_overrun(ovr_a), .dbg_state(st_a)
  );

  // dut_b
  logic [23:0] ov_thr_b, uv_thr_b, sample_b;
  logic        sv_b, tmo_b, ovr_b;
  logic [2:0]  sch_b;
  logic [1:0]  ov_b, uv_b;
  logic [1:0]  st_b;

  xadc_chan_monitor #(
    .NUM_CH(2), .CH_ADDR({7'h16, 7'h16}), .AVG_LOG2(0),
    .HYST(12'd16), .DRDY_TIMEOUT(64)
  ) dut_b (
    .clk_ctrl(clk), .rst_ctrl(rst), .drp(if_b),
    .ov_thr(ov_thr_b), .uv_thr(uv_thr_b),
    .sample(sample_b), .sample_valid(sv_b), .sample_ch(sch_b),
    .ov_alarm(ov_b), .uv_alarm(uv_b),
    .drdy_timeout(tmo_b), .eoc_overrun(ovr_b), .dbg_state(st_b)
  );

  // dut_c
  logic [11:0] ov_thr_c, uv_thr_c, sample_c;
  logic        sv_c, tmo_c, ovr_c;
  logic [2:0]  sch_c;
  logic [0:0]  ov_c, uv_c;
  logic [1:0]  st_c;

  xadc_chan_monitor #(
    .NUM_CH(1), .CH_ADDR(7'h17), .AVG_LOG2(2),
    .HYST(12'd16), .DRDY_TIMEOUT(64)
  ) dut_c (
    .clk_ctrl(clk), .rst_ctrl(rst), .drp(if_c),
    .ov_thr(ov_thr_c), .uv_thr(uv_thr_c),
    .sample(sample_c), .sample_valid(sv_c), .sample_ch(sch_c),
    .ov_alarm(ov_c), .uv_alarm(uv_c),
    .drdy_timeout(tmo_c), .eoc_overrun(ovr_c), .dbg_state(st_c)
  );

  logic den_any;
  assign den_any = if_a.den | if_b.den | if_c.den;

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of dut_a: running sum and count of the current window
  int          sum_m [4];
  int          cnt_m [4];
  logic [11:0] samp_m [4];
  bit          ov_m [4];
  bit          uv_m [4];
  int          thr_ov [4];
  int          thr_uv [4];
  logic [4:0]  addr_a [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ov_rule(input bit prev, input int avg, input int thr);
    int lo;
    lo = thr - HYST;
    if (lo < 0) lo = 0;
    if (avg > thr) return 1'b1;
    if (avg < lo) return 1'b0;
    return prev;
  endfunction

  function automatic bit uv_rule(input bit prev, input int avg, input int thr);
    int hi;
    hi = thr + HYST;
    if (hi > 4095) hi = 4095;
    if (avg < thr) return 1'b1;
    if (avg > hi) return 1'b0;
    return prev;
  endfunction

  function automatic logic [47:0] pack_samp();
    logic [47:0] r;
    for (int i = 0; i < 4; i++) r[i*12 +: 12] = samp_m[i];
    return r;
  endfunction

  function automatic logic [3:0] pack_ov();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ov_m[i];
    return r;
  endfunction

  function automatic logic [3:0] pack_uv();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = uv_m[i];
    return r;
  endfunction

  function automatic logic [6:0] daddr_of(input int which);
    case (which)
      0:       return if_a.daddr;
      1:       return if_b.daddr;
      default: return if_c.daddr;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sum_m[i] = 0; cnt_m[i] = 0; samp_m[i] = 12'd0; ov_m[i] = 1'b0; uv_m[i] = 1'b0;
    end
  endtask

  // Driver: one EOC, one DRP read answered after a random delay. Returns at
  // the negedge where the resulting sample_valid is expected.
  task automatic do_read(input int which, input logic [4:0] addr,
                         input logic [11:0] code, input bit inject_ovr);
    int d;
    @(negedge clk); eoc = 1'b1; chan = addr;
    @(negedge clk); eoc = 1'b0;
    chk("den_issued", den_any, 1'b1);
    chk("daddr", daddr_of(which), {2'b00, addr});
    if (inject_ovr) begin
      @(negedge clk);
      @(negedge clk); eoc = 1'b1; chan = addr;
      @(negedge clk); eoc = 1'b0;
      chk("den_blocked", den_any, 1'b0);
    end
    d = $urandom_range(0, 4);
    repeat (d) @(negedge clk);
    drdy = 1'b1; dout = {code, 4'($urandom_range(0, 15))};
    @(negedge clk); drdy = 1'b0;
    @(negedge clk);
  endtask

  // Read on dut_a channel ch, update the model and compare everything.
  task automatic read_a(input int ch, input logic [11:0] code, input bit inject);
    bit exp_v;
    int avg;
    do_read(0, addr_a[ch], code, inject);
    exp_v = 1'b0;
    sum_m[ch] += int'(code);
    cnt_m[ch] += 1;
    if (cnt_m[ch] == 4) begin
      avg        = sum_m[ch] / 4;
      samp_m[ch] = 12'(avg);
      ov_m[ch]   = ov_rule(ov_m[ch], avg, thr_ov[ch]);
      uv_m[ch]   = uv_rule(uv_m[ch], avg, thr_uv[ch]);
      sum_m[ch]  = 0;
      cnt_m[ch]  = 0;
      exp_v      = 1'b1;
    end
    chk("a_valid", sv_a, exp_v);
    if (exp_v) chk("a_sample_ch", sch_a, 3'(ch));
    chk("a_sample", sample_a, pack_samp());
    chk("a_ov", ov_a, pack_ov());
    chk("a_uv", uv_a, pack_uv());
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_den"}, if_a.den, 1'b0);
    chk({tag, "_daddr"}, if_a.daddr, 7'd0);
    chk({tag, "_state"}, st_a, ST_IDLE);
    chk({tag, "_sample"}, sample_a, 48'd0);
    chk({tag, "_valid"}, sv_a, 1'b0);
    chk({tag, "_ch"}, sch_a, 3'd0);
    chk({tag, "_alarms"}, {ov_a, uv_a}, 8'd0);
    chk({tag, "_flags"}, {tmo_a, ovr_a}, 2'd0);
  endtask

  // Directed/random sequence
  initial begin
    int waited;
    logic [11:0] code;
    logic [11:0] hyst_codes [6];
    bit          hyst_ov [6];

    rst = 1'b1; eoc = 1'b0; drdy = 1'b0; chan = 5'd0; dout = 16'd0;
    addr_a[0] = 5'h15; addr_a[1] = 5'h11; addr_a[2] = 5'h12; addr_a[3] = 5'h13;
    for (int i = 0; i < 3; i++) begin
      thr_ov[i] = $urandom_range(1800, 2600);
      thr_uv[i] = $urandom_range(1400, 2200);
    end
    // Channel 3 exercises release-threshold saturation at both ends.
    thr_ov[3] = 5;
    thr_uv[3] = 4090;
    for (int i = 0; i < 4; i++) begin
      ov_thr_a[i*12 +: 12] = 12'(thr_ov[i]);
      uv_thr_a[i*12 +: 12] = 12'(thr_uv[i]);
    end
    ov_thr_b = {12'd4095, 12'd3000};
    uv_thr_b = 24'd0;
    ov_thr_c = 12'd4095;
    uv_thr_c = 12'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk_a_zero("reset");
    rst = 1'b0;

    // Unknown channel: no read, no state change, no flags.
    @(negedge clk); eoc = 1'b1; chan = 5'h04;
    @(negedge clk); eoc = 1'b0;
    chk("unk_den", den_any, 1'b0);
    chk("unk_state", st_a, ST_IDLE);
    chk("unk_flags", {tmo_a, ovr_a}, 2'd0);

    // Four reads averaged into one sample.
    for (int k = 0; k < 4; k++) begin
      do_read(2, 5'h17, 12'(100 * (k + 1)), 1'b0);
      chk("c_valid", sv_c, (k == 3));
    end
    chk("c_sample", sample_c, 12'd250);
    chk("c_sample_ch", sch_c, 3'd0);
    @(negedge clk);
    chk("c_valid_one_cycle", sv_c, 1'b0);

    // Over-voltage hysteresis with no averaging; duplicate address -> index 0.
    hyst_codes[0] = 12'd3000; hyst_ov[0] = 1'b0;
    hyst_codes[1] = 12'd3001; hyst_ov[1] = 1'b1;
    hyst_codes[2] = 12'd3000; hyst_ov[2] = 1'b1;
    hyst_codes[3] = 12'd2990; hyst_ov[3] = 1'b1;
    hyst_codes[4] = 12'd2984; hyst_ov[4] = 1'b1;
    hyst_codes[5] = 12'd2983; hyst_ov[5] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_read(1, 5'h16, hyst_codes[k], 1'b0);
      chk("b_valid", sv_b, 1'b1);
      chk("b_sample_ch", sch_b, 3'd0);
      chk("b_sample", sample_b, {12'd0, hyst_codes[k]});
      chk("b_ov", ov_b, {1'b0, hyst_ov[k]});
      chk("b_uv", uv_b, 2'b00);
    end

    // Randomized traffic on dut_a.
    for (int k = 0; k < 80; k++) begin
      read_a($urandom_range(0, 3), 12'($urandom_range(0, 4095)), 1'b0);
    end
    chk("a_flags_clean", {tmo_a, ovr_a}, 2'd0);

    // DRP read never answered.
    @(negedge clk); eoc = 1'b1; chan = 5'h11;
    @(negedge clk); eoc = 1'b0;
    chk("tmo_den", if_a.den, 1'b1);
    waited = 0;
    while (st_a != ST_IDLE && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("tmo_window", (waited >= 63 && waited <= 65), 1'b1);
    chk("tmo_flag", tmo_a, 1'b1);
    chk("tmo_state", st_a, ST_IDLE);
    read_a(1, 12'($urandom_range(0, 4095)), 1'b0);

    // EOC during an in-flight read; the dropped one must not accumulate.
    read_a(2, 12'($urandom_range(0, 4095)), 1'b1);
    chk("ovr_flag", ovr_a, 1'b1);
    for (int k = 0; k < 4; k++) read_a(2, 12'($urandom_range(0, 4095)), 1'b0);
    chk("sticky_flags", {tmo_a, ovr_a}, 2'b11);

    // Reset in WAIT with channel 0 partially accumulated.
    for (int k = 0; k < 4 && cnt_m[0] != 2; k++) read_a(0, 12'($urandom_range(0, 4095)), 1'b0);
    chk("pre_rst_cnt", cnt_m[0], 2);
    @(negedge clk); eoc = 1'b1; chan = 5'h15;
    @(negedge clk); eoc = 1'b0;
    chk("rst_den", if_a.den, 1'b1);
    #1 rst = 1'b1;
    #1 chk_a_zero("inrst");
    @(negedge clk); rst = 1'b0;
    drdy = 1'b1; dout = {12'd4000, 4'd0};
    @(negedge clk); drdy = 1'b0;
    @(negedge clk);
    chk("late_drdy_state", st_a, ST_IDLE);
    chk("late_drdy_valid", sv_a, 1'b0);
    chk("late_drdy_sample", sample_a, 48'd0);
    model_reset();
    for (int k = 0; k < 4; k++) read_a(0, 12'($urandom_range(0, 4095)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
